seq_pattern_gen: RTL and testbench

- Serial bit-pattern transmitter. Emits a latched PAT_W-bit pattern MSB-first, one bit per clock, repeated a programmable number of times.
- Transmit-side counterpart of the team's run-of-ones sequence detectors. It drives their seq input in-system and on benches.
- Controlled by a start/busy/done handshake from a host FSM or testbench sequencer.

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq_down_counter.sv | 26 ++
 rtl/seq_pattern_gen.sv | 184 ++++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants for the serial pattern transmitter: state encoding and default widths.
package seq_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PRE   = 3'd1;
    localparam logic [2:0] GUARD = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;

    localparam int PAT_W_DEF   = 8;
    localparam int CNT_W_DEF   = 4;
    localparam int PRE_LEN_DEF = 8;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with zero flag; saturates at zero, load has priority over decrement.
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated repeat_n times.
// Optional preamble of PRE_LEN ones plus one guard zero when SEQ_PREAMBLE_EN is defined.
//
// state | meaning
// IDLE  | outputs low, waiting for start
// PRE   | preamble ones (SEQ_PREAMBLE_EN only)
// GUARD | single zero separating preamble from payload (SEQ_PREAMBLE_EN only)
// SHIFT | payload bits, idx/reps counters advance
// FIN   | done pulse; start here begins the next frame
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int PAT_W   = PAT_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PRE_LEN = PRE_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             seq_out,
    output logic             seq_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    logic [2:0]       state_q, state_d;
    logic [PAT_W-1:0] pat_q;
    logic             pat_load;
    logic             out_d, valid_d, busy_d, done_d;

    logic             idx_load, idx_dec, idx_zero;
    logic [IDX_W-1:0] idx_cnt, idx_nxt;
    logic             rep_load, rep_dec, rep_zero;
    logic [CNT_W-1:0] rep_cnt, rep_init;
    logic             unused_cnt;

    assign idx_nxt  = idx_cnt - IDX_W'(1);
    assign rep_init = (repeat_n == '0) ? CNT_W'(1) : repeat_n;

    seq_down_counter #(.W(IDX_W)) u_idx (
        .clk      (clk),
        .rst      (rst),
        .load     (idx_load),
        .load_val (IDX_W'(PAT_W - 1)),
        .dec      (idx_dec),
        .cnt      (idx_cnt),
        .zero     (idx_zero)
    );

    seq_down_counter #(.W(CNT_W)) u_rep (
        .clk      (clk),
        .rst      (rst),
        .load     (rep_load),
        .load_val (rep_init),
        .dec      (rep_dec),
        .cnt      (rep_cnt),
        .zero     (rep_zero)
    );

`ifdef SEQ_PREAMBLE_EN
    localparam int PRE_W = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;

    logic             pre_load, pre_dec, pre_zero;
    logic [PRE_W-1:0] pre_cnt;

    // Counter holds the preamble cycles still to come after the current one.
    seq_down_counter #(.W(PRE_W)) u_pre (
        .clk      (clk),
        .rst      (rst),
        .load     (pre_load),
        .load_val (PRE_W'(PRE_LEN - 1)),
        .dec      (pre_dec),
        .cnt      (pre_cnt),
        .zero     (pre_zero)
    );

    assign unused_cnt = ^{rep_zero, pre_cnt};
`else
    localparam int unused_pre_len = PRE_LEN;

    assign unused_cnt = rep_zero;
`endif

    always_comb begin
        state_d  = IDLE;
        out_d    = 1'b0;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        pat_load = 1'b0;
        idx_load = 1'b0;
        idx_dec  = 1'b0;
        rep_load = 1'b0;
        rep_dec  = 1'b0;
`ifdef SEQ_PREAMBLE_EN
        pre_load = 1'b0;
        pre_dec  = 1'b0;
`endif
        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    pat_load = 1'b1;
                    idx_load = 1'b1;
                    rep_load = 1'b1;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
`ifdef SEQ_PREAMBLE_EN
                    pre_load = 1'b1;
                    state_d  = PRE;
                    out_d    = 1'b1;
`else
                    // pat_q is not yet loaded, so the first bit comes straight from the input.
                    state_d  = SHIFT;
                    out_d    = pattern[PAT_W-1];
`endif
                end
            end
`ifdef SEQ_PREAMBLE_EN
            PRE: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                if (pre_zero) begin
                    state_d = GUARD;
                end else begin
                    pre_dec = 1'b1;
                    state_d = PRE;
                    out_d   = 1'b1;
                end
            end
            GUARD: begin
                state_d = SHIFT;
                out_d   = pat_q[PAT_W-1];
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
`endif
            SHIFT: begin
                if (!idx_zero) begin
                    idx_dec = 1'b1;
                    state_d = SHIFT;
                    out_d   = pat_q[idx_nxt];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (rep_cnt > CNT_W'(1)) begin
                    idx_load = 1'b1;
                    rep_dec  = 1'b1;
                    state_d  = SHIFT;
                    out_d    = pat_q[PAT_W-1];
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            seq_out   <= 1'b0;
            seq_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            seq_out   <= out_d;
            seq_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
            if (pat_load) begin
                pat_q <= pattern;
            end
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: frames queued as expected bit streams, checked by a monitor.
module tb_seq_pattern_gen;

    localparam int PAT_W   = 8;
    localparam int CNT_W   = 4;
    localparam int PRE_LEN = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_n;
    logic             seq_out, seq_valid, busy, done;

    int checks   = 0;
    int failures = 0;
    bit exp_bits[$];
    int exp_len[$];
    int cur_cnt  = 0;
    int run      = 0;
    int max_run  = 0;
    bit mon_en   = 1'b0;

    seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .PRE_LEN(PRE_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pattern   (pattern),
        .repeat_n  (repeat_n),
        .seq_out   (seq_out),
        .seq_valid (seq_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the frame is just the optional preamble followed by the pattern bits, reps times.
    function automatic int push_frame(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] rn);
        int reps = (rn == 0) ? 1 : int'(rn);
        int n = 0;
`ifdef SEQ_PREAMBLE_EN
        for (int i = 0; i < PRE_LEN; i++) exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b0);
        n = PRE_LEN + 1;
`endif
        for (int r = 0; r < reps; r++)
            for (int b = PAT_W - 1; b >= 0; b--) exp_bits.push_back(p[b]);
        n += PAT_W * reps;
        exp_len.push_back(n);
        return n;
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("busy_matches_valid", busy, seq_valid);
            if (seq_valid) begin
                chk("bit_expected", exp_bits.size() > 0, 1);
                if (exp_bits.size() > 0) chk("seq_bit", seq_out, exp_bits.pop_front());
                cur_cnt++;
                run = seq_out ? run + 1 : 0;
                if (run > max_run) max_run = run;
            end else begin
                chk("idle_out_low", seq_out, 0);
                run = 0;
            end
            if (done) begin
                chk("done_expected", exp_len.size() > 0, 1);
                if (exp_len.size() > 0) chk("frame_len", cur_cnt, exp_len.pop_front());
                cur_cnt = 0;
            end
        end
    end

    // Called one ns after a clock edge with the DUT idle or in FIN; returns in the FIN cycle.
    task automatic send(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] rn,
                        input int disturb_at, input logic [PAT_W-1:0] dpat);
        int len;
        start    = 1'b1;
        pattern  = p;
        repeat_n = rn;
        len = push_frame(p, rn);
        @(posedge clk); #1;
        for (int i = 1; i <= len; i++) begin
            start = (i == disturb_at);
            if (disturb_at > 0) pattern = (i >= disturb_at) ? dpat : p;
            else                pattern = PAT_W'($urandom);
            repeat_n = CNT_W'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        pattern  = '0;
        repeat_n = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seq_out", seq_out, 0);
        chk("rst_seq_valid", seq_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        idle(2);

        send(8'hA5, 4'd1, 0, 8'h00);
        idle(2);
        send(8'h81, 4'd0, 0, 8'h00);
        idle(1);
        max_run = 0;
        send(8'hFF, 4'd3, 0, 8'h00);
        chk("ones_run_24", max_run >= 24, 1);
        send(8'hA5, 4'd1, 4, 8'h00);
        idle(3);

        // Asynchronous abort in the middle of a frame.
        start    = 1'b1;
        pattern  = 8'hA5;
        repeat_n = 4'd1;
        void'(push_frame(8'hA5, 4'd1));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_seq_out", seq_out, 0);
        chk("abort_seq_valid", seq_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        exp_bits.delete();
        exp_len.delete();
        cur_cnt = 0;
        run     = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        send(8'h3C, 4'd2, 0, 8'h00);
        idle(1);

        for (int f = 0; f < 25; f++) begin
            logic [PAT_W-1:0] p;
            logic [CNT_W-1:0] rn;
            int dis;
            p   = PAT_W'($urandom);
            rn  = ($urandom_range(0, 7) == 0) ? CNT_W'(15) : CNT_W'($urandom_range(0, 3));
            dis = ($urandom_range(0, 2) == 0) ? $urandom_range(1, PAT_W) : 0;
            send(p, rn, dis, PAT_W'($urandom));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        idle(4);
        chk("bits_left", exp_bits.size(), 0);
        chk("frames_left", exp_len.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
